alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Sequencer in front of the 32-bit ALU/shifter/multiplier/HI-LO datapath.
- Accepts one operation at a time over a valid/ready request channel.
- Drives the datapath's 6-bit funct signal and operands for the required number of cycles (1 for ALU/shift/move ops, MUL_CYCLES for MULTU).
- Returns results over a valid/ready response channel; tracks HI/LO validity.

Parameters:
- DATA_W, 32, operand/result width
- FUNCT_W, 6, funct code width
- MUL_CYCLES, 32, cycles MULTU must be held on the datapath (>=2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept request
- req_funct  in  FUNCT_W  operation code
- req_a  in  DATA_W  operand A
- req_b  in  DATA_W  operand B
- alu_signal  out  FUNCT_W  funct to datapath
- alu_dataA  out  DATA_W  operand A to datapath
- alu_dataB  out  DATA_W  operand B to datapath
- alu_result  in  DATA_W  datapath Output
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_data  out  DATA_W  result
- rsp_err  out  1  illegal op or HI/LO read before any MULTU
- busy  out  1  state != IDLE

Behaviour:
- Funct codes: AND=36, OR=37, ADD=32, SUB=34, SLT=42, SLL=0, MULTU=25, MFHI=16, MFLO=18.
- NOP=6'b111111 is driven on alu_signal whenever no operation is issued.
- Reset (async, reset=0): state=IDLE, req_ready=0 during reset, rsp_valid=0, rsp_data=0, rsp_err=0, alu_signal=NOP, alu_dataA/B=0, hilo_valid=0, counter=0.
- Reset mid-operation aborts the operation; the response is lost.
- FSM states: IDLE, EXEC, MUL, RESP.
- IDLE: req_ready=1. On req_valid, register funct/a/b.
  - ALU, shift, MFHI or MFLO -> EXEC.
  - MULTU -> MUL, counter=0.
  - Illegal funct -> RESP with rsp_data=0, rsp_err=1; nothing is driven to the datapath.
- EXEC (1 cycle): alu_signal/dataA/dataB = registered request. At the clock edge, capture alu_result into rsp_data -> RESP.
  - MFHI/MFLO with hilo_valid=0: rsp_data=0, rsp_err=1.
- MUL: hold alu_signal=MULTU and the operands. Counter increments each cycle.
  - When counter==MUL_CYCLES-1: set hilo_valid=1 -> IDLE. No response is generated for MULTU.
  - Latency: MUL_CYCLES cycles from acceptance to req_ready.
- RESP: rsp_valid=1, rsp_data/rsp_err stable. When rsp_ready=1 at the clock edge -> IDLE.
  - req_ready=0 throughout RESP, so no new acceptance happens in the same cycle.
- Throughput: ALU op latency is 2 cycles (accept -> EXEC -> rsp_valid). Back-to-back ALU ops take a minimum of 3 cycles each.
- req_ready is combinational on state only, with no dependency on req_valid.
- hilo_valid is never cleared except by reset. A new MULTU overwrites HI/LO.

Optional Feature:
- Macro: ALU_PERF_CNT_EN.
- Defined: adds outputs op_count [31:0] and mul_count [31:0].
  - op_count increments on every accepted request, including illegal ones.
  - mul_count increments on every accepted MULTU.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_ctrl_pkg holds the funct localparams (AND, OR, ADD, SUB, SLT, SLL, MULTU, MFHI, MFLO, NOP) and the FSM state encoding (2-bit).
- One sub-module: alu_funct_decode (combinational). Input funct; outputs is_single, is_mul, is_hilo, is_illegal.

Test Plan:
- ADD: a=5, b=7, funct=32 -> alu_signal=32 for exactly 1 cycle. With datapath returning 12, rsp_data=12, rsp_err=0. rsp_valid is held 3 extra cycles while rsp_ready=0, with stable data.
- MFHI before any MULTU: funct=16 -> rsp_data=0, rsp_err=1.
- MULTU: a=0xFFFFFFFF, b=2 -> alu_signal=25 for exactly 32 cycles, req_ready=0 for that time, no rsp_valid. A following MFHI/MFLO returns the datapath values with rsp_err=0.
- Illegal funct=63: req accepted -> rsp_valid next cycle, rsp_data=0, rsp_err=1. alu_signal stays NOP.
- Reset asserted at MUL counter=10 -> immediately state=IDLE, alu_signal=NOP, busy=0. A subsequent MFLO gives rsp_err=1.
- ALU_PERF_CNT_EN: ADD, MULTU, illegal, SUB -> op_count=4, mul_count=1.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: funct codes and FSM state encoding shared by the ALU issue controller.
package alu_ctrl_pkg;

  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_NOP   = 6'b111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/alu_funct_decode.sv
// alu_funct_decode: classifies a funct code into single-cycle, multiply, HI/LO move or illegal.
module alu_funct_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6
) (
  input  logic [FUNCT_W-1:0] funct,
  output logic               is_single,
  output logic               is_mul,
  output logic               is_hilo,
  output logic               is_illegal
);

  assign is_single = funct inside {FUNCT_W'(F_AND), FUNCT_W'(F_OR), FUNCT_W'(F_ADD),
                                   FUNCT_W'(F_SUB), FUNCT_W'(F_SLT), FUNCT_W'(F_SLL)};
  assign is_mul     = funct == FUNCT_W'(F_MULTU);
  assign is_hilo    = funct inside {FUNCT_W'(F_MFHI), FUNCT_W'(F_MFLO)};
  assign is_illegal = !(is_single || is_mul || is_hilo);

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one request at a time to the ALU/shift/mul/HI-LO datapath and returns results.
// Defining ALU_PERF_CNT_EN adds the op_count/mul_count performance counter outputs.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FUNCT_W    = 6,
  parameter int MUL_CYCLES = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [FUNCT_W-1:0] req_funct,
  input  logic [DATA_W-1:0]  req_a,
  input  logic [DATA_W-1:0]  req_b,
  output logic [FUNCT_W-1:0] alu_signal,
  output logic [DATA_W-1:0]  alu_dataA,
  output logic [DATA_W-1:0]  alu_dataB,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_err,
  output logic               busy
`ifdef ALU_PERF_CNT_EN
  ,
  output logic [31:0]        op_count,
  output logic [31:0]        mul_count
`endif
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

  state_e             state_q, state_d;
  logic [FUNCT_W-1:0] funct_q, funct_d, dec_funct;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, data_q, data_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               hilo_valid_q, hilo_valid_d, err_q, err_d;
  logic               is_single, is_mul, is_hilo, is_illegal;
  logic               accept, drive;

  // In IDLE the incoming request is classified; afterwards the registered one.
  assign dec_funct = (state_q == IDLE) ? req_funct : funct_q;

  alu_funct_decode #(.FUNCT_W(FUNCT_W)) u_decode (
    .funct      (dec_funct),
    .is_single  (is_single),
    .is_mul     (is_mul),
    .is_hilo    (is_hilo),
    .is_illegal (is_illegal)
  );

  assign req_ready  = (state_q == IDLE) && reset;
  assign accept     = req_valid && req_ready;
  assign drive      = (state_q == EXEC) || (state_q == MUL);
  assign alu_signal = drive ? funct_q : FUNCT_W'(F_NOP);
  assign alu_dataA  = drive ? a_q : '0;
  assign alu_dataB  = drive ? b_q : '0;
  assign rsp_valid  = state_q == RESP;
  assign rsp_data   = data_q;
  assign rsp_err    = err_q;
  assign busy       = state_q != IDLE;

  always_comb begin
    state_d      = state_q;
    funct_d      = funct_q;
    a_d          = a_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    hilo_valid_d = hilo_valid_q;
    data_d       = data_q;
    err_d        = err_q;
    unique case (state_q)
      IDLE: if (accept) begin
        funct_d = req_funct;
        a_d     = req_a;
        b_d     = req_b;
        cnt_d   = '0;
        data_d  = '0;
        err_d   = is_illegal;
        state_d = is_mul ? MUL : (is_single || is_hilo) ? EXEC : RESP;
      end
      EXEC: begin
        err_d   = is_hilo && !hilo_valid_q;
        data_d  = (is_hilo && !hilo_valid_q) ? '0 : alu_result;
        state_d = RESP;
      end
      MUL: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          hilo_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      funct_q      <= FUNCT_W'(F_NOP);
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      hilo_valid_q <= 1'b0;
      data_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      funct_q      <= funct_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      hilo_valid_q <= hilo_valid_d;
      data_q       <= data_d;
      err_q        <= err_d;
    end
  end

`ifdef ALU_PERF_CNT_EN
  logic [31:0] op_cnt_q, mul_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_cnt_q  <= '0;
      mul_cnt_q <= '0;
    end else if (accept) begin
      op_cnt_q  <= op_cnt_q + 32'd1;
      mul_cnt_q <= mul_cnt_q + {31'd0, is_mul};
    end
  end

  assign op_count  = op_cnt_q;
  assign mul_count = mul_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench for alu_issue_ctrl with a behavioural datapath stand-in.
module tb_alu_issue_ctrl;
  import alu_ctrl_pkg::*;

  localparam int MC = 32;

  logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0, rsp_ready = 1'b1;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [5:0]  req_funct = 6'd0, alu_signal;
  logic [31:0] req_a = 32'd0, req_b = 32'd0, alu_dataA, alu_dataB, alu_result, rsp_data;
  logic [31:0] hi_m = 32'hDEADBEEF, lo_m = 32'hCAFEF00D;
`ifdef ALU_PERF_CNT_EN
  logic [31:0] op_count, mul_count;
`endif
  logic [32:0] sb[$];
  int          vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b),
    .alu_signal(alu_signal), .alu_dataA(alu_dataA), .alu_dataB(alu_dataB),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
`ifdef ALU_PERF_CNT_EN
    , .op_count(op_count), .mul_count(mul_count)
`endif
  );

  // Datapath stand-in; HI/LO start with junk so ungated reads are visible.
  always_comb begin
    case (alu_signal)
      F_AND:   alu_result = alu_dataA & alu_dataB;
      F_OR:    alu_result = alu_dataA | alu_dataB;
      F_ADD:   alu_result = alu_dataA + alu_dataB;
      F_SUB:   alu_result = alu_dataA - alu_dataB;
      F_SLT:   alu_result = ($signed(alu_dataA) < $signed(alu_dataB)) ? 32'd1 : 32'd0;
      F_SLL:   alu_result = alu_dataA << alu_dataB[4:0];
      F_MFHI:  alu_result = hi_m;
      F_MFLO:  alu_result = lo_m;
      default: alu_result = 32'h0BAD0BAD;
    endcase
  end

  always_ff @(posedge clk)
    if (alu_signal == F_MULTU) {hi_m, lo_m} <= 64'(alu_dataA) * 64'(alu_dataB);

  task automatic do_op(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ed, input logic ee, input int lat, input int ndrv);
    logic [32:0] exp;
    int n = 0, d = 0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_funct = f; req_a = a; req_b = b;
    sb.push_back({ee, ed});
    @(negedge clk);
    req_valid = 1'b0;
    while (rsp_valid !== 1'b1 && n < 10) begin
      if (alu_signal !== F_NOP) d++;
      @(negedge clk);
      n++;
    end
    exp = sb.pop_front();
    vectors++;
    if (rsp_valid !== 1'b1 || n != lat || d != ndrv) begin
      miscompares++;
      $display("FAIL %s timing: got valid=%b lat=%0d drv=%0d want valid=1 lat=%0d drv=%0d",
               name, rsp_valid, n, d, lat, ndrv);
    end
    vectors++;
    if ({rsp_err, rsp_data} !== exp) begin
      miscompares++;
      $display("FAIL %s result: got err=%b data=%h want err=%b data=%h", name, rsp_err, rsp_data, exp[32], exp[31:0]);
    end
    @(negedge clk);
  endtask

  task automatic do_mul(input string name, input logic [31:0] a, input logic [31:0] b);
    int ns = 0, nr = 0, nb = 0, nv = 0, nop = 0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_funct = F_MULTU; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < MC + 4; i++) begin
      if (alu_signal === F_MULTU) begin
        ns++;
        if (alu_dataA !== a || alu_dataB !== b) nop++;
      end
      if (req_ready !== 1'b1) nr++;
      if (busy === 1'b1) nb++;
      if (rsp_valid !== 1'b0) nv++;
      @(negedge clk);
    end
    vectors++;
    if (ns != MC || nr != MC || nb != MC) begin
      miscompares++;
      $display("FAIL %s cycles: got sig=%0d notready=%0d busy=%0d want %0d each", name, ns, nr, nb, MC);
    end
    vectors++;
    if (nv != 0 || nop != 0) begin
      miscompares++;
      $display("FAIL %s hold: got rsp_cycles=%0d bad_operands=%0d want 0 0", name, nv, nop);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_err, busy} !== 4'b0000 || rsp_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got ready=%b valid=%b err=%b busy=%b data=%h want all 0",
               req_ready, rsp_valid, rsp_err, busy, rsp_data);
    end
    vectors++;
    if (alu_signal !== F_NOP || alu_dataA !== 32'd0 || alu_dataB !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_dp: got sig=%0d a=%h b=%h want 63 0 0", alu_signal, alu_dataA, alu_dataB);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got ready=%b busy=%b want 1 0", req_ready, busy);
    end
  endtask

  task automatic test_mfhi_before_mul();
    do_op("mfhi_early", F_MFHI, 32'd0, 32'd0, 32'd0, 1'b1, 1, 1);
    do_op("mflo_early", F_MFLO, 32'd0, 32'd0, 32'd0, 1'b1, 1, 1);
  endtask

  task automatic test_add_hold();
    logic [32:0] exp;
    int nsig = 0, nbad = 0;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_funct = F_ADD; req_a = 32'd5; req_b = 32'd7;
    sb.push_back({1'b0, 32'd12});
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (alu_signal === F_ADD) nsig++;
      if (i > 0 && {rsp_valid, rsp_err, rsp_data} !== {1'b1, sb[0]}) nbad++;
      @(negedge clk);
    end
    vectors++;
    if (nsig != 1) begin
      miscompares++;
      $display("FAIL add_issue: got %0d cycles of funct 32 want 1", nsig);
    end
    vectors++;
    if (nbad != 0) begin
      miscompares++;
      $display("FAIL add_stall: got %0d unstable response cycles want 0", nbad);
    end
    exp = sb.pop_front();
    rsp_ready = 1'b1;
    vectors++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, exp}) begin
      miscompares++;
      $display("FAIL add_result: got valid=%b err=%b data=%h want 1 %b %h", rsp_valid, rsp_err, rsp_data, exp[32], exp[31:0]);
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL add_release: got valid=%b busy=%b want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_alu_ops();
    do_op("and", F_AND, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1, 1);
    do_op("or",  F_OR,  32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, 1, 1);
    do_op("sub", F_SUB, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1, 1);
    do_op("slt_neg", F_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1, 1);
    do_op("slt_pos", F_SLT, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1, 1);
    do_op("sll", F_SLL, 32'd3, 32'd4, 32'd48, 1'b0, 1, 1);
  endtask

  task automatic test_illegal();
    do_op("illegal63", 6'd63, 32'd1, 32'd2, 32'd0, 1'b1, 0, 0);
    do_op("illegal1", 6'd1, 32'd1, 32'd2, 32'd0, 1'b1, 0, 0);
  endtask

  task automatic test_multu();
    do_mul("multu", 32'hFFFFFFFF, 32'd2);
    do_op("mfhi", F_MFHI, 32'd0, 32'd0, 32'h00000001, 1'b0, 1, 1);
    do_op("mflo", F_MFLO, 32'd0, 32'd0, 32'hFFFFFFFE, 1'b0, 1, 1);
  endtask

  task automatic test_back_to_back();
    int nacc = 0, nrsp = 0, nbad = 0;
    sb.delete();
    @(negedge clk);
    req_valid = 1'b1; req_funct = F_ADD; req_a = 32'd1; req_b = 32'd2;
    for (int i = 0; i < 9; i++) begin
      if (req_ready === 1'b1) begin
        nacc++;
        sb.push_back({1'b0, 32'd3});
      end
      if (rsp_valid === 1'b1) begin
        nrsp++;
        if (sb.size() == 0) nbad++;
        else if ({rsp_err, rsp_data} !== sb.pop_front()) nbad++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    vectors++;
    if (nacc != 3 || nrsp != 3) begin
      miscompares++;
      $display("FAIL b2b_rate: got accepts=%0d responses=%0d want 3 3", nacc, nrsp);
    end
    vectors++;
    if (nbad != 0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_data: got bad=%0d pending=%0d want 0 0", nbad, sb.size());
    end
  endtask

  task automatic test_reset_mid_mul();
    @(negedge clk);
    req_valid = 1'b1; req_funct = F_MULTU; req_a = 32'd3; req_b = 32'd4;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (alu_signal !== F_MULTU || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmul_pre: got sig=%0d busy=%b want 25 1", alu_signal, busy);
    end
    #1 reset = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || alu_signal !== F_NOP || alu_dataA !== 32'd0 || req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmul_abort: got busy=%b sig=%0d a=%h ready=%b want 0 63 0 0", busy, alu_signal, alu_dataA, req_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    do_op("mflo_after_rst", F_MFLO, 32'd0, 32'd0, 32'd0, 1'b1, 1, 1);
  endtask

`ifdef ALU_PERF_CNT_EN
  task automatic test_perf();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    do_op("perf_add", F_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1, 1);
    do_mul("perf_mul", 32'd6, 32'd7);
    do_op("perf_ill", 6'd63, 32'd0, 32'd0, 32'd0, 1'b1, 0, 0);
    do_op("perf_sub", F_SUB, 32'd9, 32'd4, 32'd5, 1'b0, 1, 1);
    vectors++;
    if (op_count !== 32'd4 || mul_count !== 32'd1) begin
      miscompares++;
      $display("FAIL perf_cnt: got op=%0d mul=%0d want 4 1", op_count, mul_count);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mfhi_before_mul();
    test_add_hold();
    test_alu_ops();
    test_illegal();
    test_multu();
    test_back_to_back();
    test_reset_mid_mul();
`ifdef ALU_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
